div4_seq_ctrl: RTL and testbench



---
 rtl/div4_pkg.sv | 11 +
 rtl/sub4_core.sv | 20 ++
 rtl/div4_seq_ctrl.sv | 104 ++++++++++
 tb/tb_div4_seq_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/div4_pkg.sv
// Shared types and constants for the 4-bit sequential restoring divider.
package div4_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int         ITER          = 4;
    localparam logic [3:0] ZERO_QUOT_DEF = 4'hF;
endpackage

// File: rtl/sub4_core.sv
// 4-bit ripple subtractor a - b as a + ~b + 1; carry=1 means no borrow (a >= b).
module sub4_core (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] diff,
    output logic       carry
);
    logic [4:0] c;
    logic [3:0] bn;

    assign bn   = ~b;
    assign c[0] = 1'b1;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign diff[i]  = a[i] ^ bn[i] ^ c[i];
        assign c[i+1]   = (a[i] & bn[i]) | (c[i] & (a[i] ^ bn[i]));
    end

    assign carry = c[4];
endmodule

// File: rtl/div4_seq_ctrl.sv
// Sequential restoring divider: one shared subtractor, one quotient bit per RUN cycle,
// start/done handshake, divide-by-zero short-circuits straight to DONE.
module div4_seq_ctrl
    import div4_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] ZERO_QUOT = ZERO_QUOT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);
    localparam int         CW   = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    state_t           state, nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] q_reg, d_reg;
    // Partial remainder before the last iteration is below 2^3, so only three
    // bits are kept between iterations; the full 4-bit value goes straight out.
    logic [WIDTH-2:0] r_reg;
    logic [WIDTH-1:0] p, diff, q_nxt, r_nxt;
    logic             carry;

    assign p     = {r_reg, q_reg[WIDTH-1]};
    assign q_nxt = {q_reg[WIDTH-2:0], carry};
    assign r_nxt = carry ? diff : p;

    sub4_core u_sub (
        .a     (p),
        .b     (d_reg),
        .diff  (diff),
        .carry (carry)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) nxt = (divisor == '0) ? DONE : RUN;
                else       nxt = IDLE;
            end
            RUN:     if (cnt == LAST) nxt = DONE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            q_reg     <= '0;
            d_reg     <= '0;
            r_reg     <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient  <= ZERO_QUOT;
                            remainder <= dividend;
                            div_zero  <= 1'b1;
                        end else begin
                            q_reg    <= dividend;
                            d_reg    <= divisor;
                            r_reg    <= '0;
                            cnt      <= '0;
                            div_zero <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    q_reg <= q_nxt;
                    r_reg <= r_nxt[WIDTH-2:0];
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        quotient  <= q_nxt;
                        remainder <= r_nxt;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div4_seq_ctrl.sv
// Self-checking bench for div4_seq_ctrl: directed cases, exhaustive sweep and random ops
// against an arithmetic reference (/ and %).
module tb_div4_seq_ctrl;
    logic       clk = 1'b0;
    logic       rst_n, start;
    logic [3:0] dividend, divisor;
    logic       busy, done, div_zero;
    logic [3:0] quotient, remainder;

    int vectors = 0;
    int errs    = 0;

    div4_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Starts a/b (optionally in the current DONE cycle), optionally pulses a
    // stray 6/2 start during RUN sample 'inj', then checks timing and results.
    task automatic op(input logic [3:0] a, input logic [3:0] b, input bit b2b, input int inj);
        int nb, dcyc;
        logic [3:0] eq, er;
        logic       ez;
        if (!b2b) @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0;
        nb = 0; dcyc = -1;
        for (int i = 0; i < 12 && dcyc < 0; i++) begin
            if (done) dcyc = i;
            else begin
                if (busy) nb++;
                if (i == inj) begin start = 1'b1; dividend = 4'd6; divisor = 4'd2; end
                else if (i == inj + 1) start = 1'b0;
                @(negedge clk);
            end
        end
        start = 1'b0;
        if (b == 0) begin eq = 4'hF; er = a; ez = 1'b1; end
        else begin eq = a / b; er = a % b; ez = 1'b0; end
        chk("latency", 8'(dcyc), (b == 0) ? 8'd0 : 8'd4);
        chk("busy_cycles", 8'(nb), (b == 0) ? 8'd0 : 8'd4);
        chk("quotient", {4'd0, quotient}, {4'd0, eq});
        chk("remainder", {4'd0, remainder}, {4'd0, er});
        chk("div_zero", {7'd0, div_zero}, {7'd0, ez});
    endtask

    initial begin
        bit saw_done;
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);
        chk("rst_quot", {4'd0, quotient}, 8'd0);
        chk("rst_rem", {4'd0, remainder}, 8'd0);
        chk("rst_dz", {7'd0, div_zero}, 8'd0);
        rst_n = 1'b1;
        @(negedge clk);

        op(4'd13, 4'd3, 0, -1);
        @(negedge clk);
        chk("done_one_cycle", {7'd0, done}, 8'd0);
        chk("quot_held", {4'd0, quotient}, 8'd4);
        op(4'd15, 4'd1, 0, -1);
        op(4'd7, 4'd9, 0, -1);
        op(4'd15, 4'd15, 0, -1);
        op(4'd14, 4'd0, 0, -1);
        op(4'd13, 4'd3, 0, 2);
        op(4'd6, 4'd2, 1, -1);

        // Reset in the middle of RUN must abort without a done pulse.
        @(negedge clk);
        start = 1'b1; dividend = 4'd13; divisor = 4'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", {7'd0, busy}, 8'd0);
        chk("mid_rst_done", {7'd0, done}, 8'd0);
        chk("mid_rst_quot", {4'd0, quotient}, 8'd0);
        chk("mid_rst_rem", {4'd0, remainder}, 8'd0);
        chk("mid_rst_dz", {7'd0, div_zero}, 8'd0);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("no_done_after_abort", {7'd0, saw_done}, 8'd0);
        op(4'd10, 4'd4, 0, -1);

        // Exhaustive sweep, issued back-to-back to check the 5-cycle done spacing.
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                op(4'(a), 4'(b), (a + b) != 0, -1);

        repeat (40) begin
            op(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
